mac_acc: RTL

Pipelined signed multiply-accumulate stage that sits directly downstream of the 16x16 signed `multiplier`. It consumes a stream of operand pairs, multiplies each pair with an instance of `multiplier`, and accumulates the 32-bit products into a saturating accumulator. On the beat flagged last, it presents the group sum, beat count and overflow flag on a valid/ready output.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/multiplier.sv | 11 +
 rtl/mac_acc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_acc multiply-accumulate stage.
// Holds the control state enum, default widths and saturation limit helpers.
package mac_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;

    // Width of the saturation helper results; callers truncate to ACC_W.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Largest positive value of a w-bit two's complement number.
    function automatic logic [SAT_W-1:0] sat_max(input int w);
        return (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    endfunction

    // Most negative w-bit value; only the low w bits are meaningful.
    function automatic logic [SAT_W-1:0] sat_min(input int w);
        return SAT_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/multiplier.sv
// Combinational 16x16 signed multiplier.
// Ports: a_i, b_i signed operands; prod_o 32-bit signed product.
module multiplier (
    input  logic signed [15:0] a_i,
    input  logic signed [15:0] b_i,
    output logic signed [31:0] prod_o
);

    assign prod_o = a_i * b_i;

endmodule

// File: rtl/mac_acc.sv
// Pipelined signed multiply-accumulate with saturating group accumulator.
// Ports: in_* operand stream (valid/ready), out_* group result (valid/ready).
module mac_acc
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_a,
    input  logic signed [15:0] in_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_acc,
    output logic [CNT_W-1:0]   out_count,
    output logic               out_ovf
);

    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    state_e state_q, state_d;

    logic signed [15:0] a1_q, b1_q;
    logic               last1_q;
    logic               v1_q;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic               accept;
    logic               clr;
    logic signed [31:0] prod;
    logic [ACC_W:0]     sum;

    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign clr       = out_valid && out_ready;

    multiplier u_mul (
        .a_i    (a1_q),
        .b_i    (b1_q),
        .prod_o (prod)
    );

    // One guard bit: overflow shows as the top two bits disagreeing,
    // and the guard bit gives the true sign of the result.
    assign sum = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W - 31){prod[31]}}, prod};

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (v1_q) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                ovf_d = 1'b1;
                acc_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (accept && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (v1_q && last1_q) state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            last1_q <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= accept;
            if (accept) begin
                a1_q    <= in_a;
                b1_q    <= in_b;
                last1_q <= in_last;
            end
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule
